// File: rtl/serial_subtractor_seq.sv
// Bit-serial a - b, LSB first: one full-subtractor step per clock through a borrow flip-flop.
// Results register on the final step and hold until the next operation completes.
module serial_subtractor_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    // Handshake: start is sampled only in IDLE (ignored otherwise, never queued);
    // done is a single-cycle pulse and diff/borrow_out/overflow are valid from that cycle on.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;

    logic a_i;
    logic b_i;
    logic d_i;
    logic br_next;

    always_comb begin
        a_i     = a_sr[0];
        b_i     = b_sr[0];
        d_i     = a_i ^ b_i ^ br;
        br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    end

    assign busy = (state == S_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            br         <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        d_sr  <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= {d_i, d_sr[WIDTH-1:1]};
                    br   <= br_next;
                    if (cnt == LAST_CNT) begin
                        // a_i/b_i are the operand MSBs on this last step.
                        diff       <= {d_i, d_sr[WIDTH-1:1]};
                        borrow_out <= br_next;
                        overflow   <= (a_i != b_i) && (d_i != a_i);
                        done       <= 1'b1;
                        cnt        <= '0;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_seq.sv
// Self-checking bench for serial_subtractor_seq (WIDTH=32): directed table, corner sequences
// and back-to-back random operations against an arithmetic reference model.
module tb_serial_subtractor_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int start_cyc = 0;
    logic prev_done = 1'b0;

    serial_subtractor_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // done must be a single-cycle pulse
    always @(negedge clk) begin
        if (done) begin
            done_count = done_count + 1;
            checks = checks + 1;
            if (prev_done) begin
                errors = errors + 1;
                $display("FAIL done_width: done high on consecutive cycles at cycle %0d", cyc);
            end
        end
        prev_done = done;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // reference model: plain unsigned/signed arithmetic
    task automatic ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                           output logic [W-1:0] rd, output logic rbor, output logic rovf);
        longint sa;
        longint sb;
        longint sd;
        sa   = longint'($signed(ra));
        sb   = longint'($signed(rb));
        sd   = sa - sb;
        rd   = ra - rb;
        rbor = (ra < rb);
        rovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endtask

    // driver: one-cycle start pulse; start_cyc marks the sampling edge E0
    task automatic start_op(input logic [W-1:0] na, input logic [W-1:0] nb);
        @(negedge clk);
        a = na;
        b = nb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        start_cyc = cyc;
    endtask

    // waits (bounded) for done; leaves caller at the negedge where done is high
    task automatic wait_done(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] ed,
                                input logic eb, input logic eo, input int exp_lat);
        check({name, "_latency"}, W'(cyc - start_cyc), W'(exp_lat));
        check({name, "_diff"}, diff, ed);
        check({name, "_borrow"}, W'(borrow_out), W'(eb));
        check({name, "_ovf"}, W'(overflow), W'(eo));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] na, input logic [W-1:0] nb,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        bit ok;
        start_op(na, nb);
        check({name, "_busy"}, W'(busy), W'(1));
        @(negedge clk);
        wait_done(name, ok);
        if (ok) check_result(name, ed, eb, eo, W);
    endtask

    initial begin
        bit ok;
        logic [W-1:0] rd;
        logic rb;
        logic ro;
        int last_done_cyc;
        int held_done;

        vecs[0] = '{32'd5,        32'd3,        32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'd3,        32'd5,        32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'd0,        32'd1,        32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_diff", diff, W'(0));
        check("rst_borrow", W'(borrow_out), W'(0));
        check("rst_ovf", W'(overflow), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // directed table
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].exp_diff, vecs[i].exp_borrow, vecs[i].exp_ovf);
            @(negedge clk);
            check($sformatf("vec%0d_done_low", i), W'(done), W'(0));
            check($sformatf("vec%0d_hold", i), diff, vecs[i].exp_diff);
        end

        // start mid-operation is ignored; outputs hold the previous result during SHIFT
        start_op(32'd5, 32'd3);
        repeat (10) @(negedge clk);
        check("ign_hold_diff", diff, 32'hFFFF_FFFF);
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", W'(busy), W'(1));
        wait_done("ign", ok);
        if (ok) check_result("ign", 32'h2, 1'b0, 1'b0, W);
        @(negedge clk);
        run_op("after_ign", 32'd9, 32'd9, 32'h0, 1'b0, 1'b0);
        @(negedge clk);

        // reset mid-SHIFT discards the operation with no done pulse
        start_op(32'd5, 32'd3);
        repeat (10) @(negedge clk);
        held_done = done_count;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_busy", W'(busy), W'(0));
        check("mrst_diff", diff, W'(0));
        check("mrst_done", W'(done), W'(0));
        repeat (40) @(negedge clk);
        check("mrst_no_done", W'(done_count), W'(held_done));
        run_op("mrst_after", 32'd0, 32'd0, 32'h0, 1'b0, 1'b0);

        // back-to-back random operations: start is raised the cycle after done
        last_done_cyc = cyc;
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rbv;
            ra  = $urandom;
            rbv = $urandom;
            case ($urandom_range(0, 7))
                0: rbv = ra;
                1: ra = {1'b1, ra[W-2:0]};
                2: rbv = '1;
                default: ;
            endcase
            ref_sub(ra, rbv, rd, rb, ro);
            start_op(ra, rbv);
            @(negedge clk);
            wait_done("rnd", ok);
            if (!ok) break;
            check_result($sformatf("rnd%0d", n), rd, rb, ro, W);
            if (n > 0) check("rnd_interval", W'(cyc - last_done_cyc), W'(W + 2));
            last_done_cyc = cyc;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
